// File: rtl/imem_loader.sv
`default_nettype none
// ============================================================================
// Module   : imem_loader
// Purpose  : Packs a valid/ready byte stream into little-endian 32-bit words and
//            writes each word into imemory, starting at BASE_ADDR.
// Options  : define LOADER_CHECKSUM_EN to add a running word-sum output (checksum).
// Revision : 1.0
// ============================================================================
module imem_loader #(
    parameter logic [31:0] BASE_ADDR = 32'h0100_0000,
    parameter int          NUM_WORDS = 1024,
    parameter int          CNT_W     = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic             byte_valid,
    input  logic [7:0]       byte_data,
    output logic             byte_ready,
    output logic [31:0]      mem_address,
    output logic [31:0]      mem_data_in,
    output logic             mem_read_write,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] words_written
`ifdef LOADER_CHECKSUM_EN
    ,
    output logic [31:0]      checksum
`endif
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_COLLECT = 2'd1,
        S_WRITE   = 2'd2,
        S_DONE    = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] c_last_word = CNT_W'(NUM_WORDS - 1);
    localparam logic [CNT_W-1:0] c_one       = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t           r_state;
    logic [1:0]       r_byte_idx;
    logic             r_byte_ready;
    logic [31:0]      r_address;
    logic [31:0]      r_data;
    logic             r_write;
    logic             r_busy;
    logic             r_done;
    logic [CNT_W-1:0] r_count;
`ifdef LOADER_CHECKSUM_EN
    logic [31:0]      r_checksum;
`endif

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_state      <= S_IDLE;
            r_byte_idx   <= 2'd0;
            r_byte_ready <= 1'b0;
            r_address    <= BASE_ADDR;
            r_data       <= 32'd0;
            r_write      <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_count      <= '0;
`ifdef LOADER_CHECKSUM_EN
            r_checksum   <= 32'd0;
`endif
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        r_state      <= S_COLLECT;
                        r_byte_ready <= 1'b1;
                        r_busy       <= 1'b1;
                        r_done       <= 1'b0;
                        r_address    <= BASE_ADDR;
                        r_count      <= '0;
                        r_byte_idx   <= 2'd0;
`ifdef LOADER_CHECKSUM_EN
                        r_checksum   <= 32'd0;
`endif
                    end
                end
                S_COLLECT: begin
                    // Bytes land directly in the write-data register; all four lanes
                    // are overwritten before the write cycle exposes them.
                    if (byte_valid && r_byte_ready) begin
                        r_data[{r_byte_idx, 3'b000} +: 8] <= byte_data;
                        r_byte_idx <= r_byte_idx + 2'd1;
                        if (r_byte_idx == 2'd3) begin
                            r_state      <= S_WRITE;
                            r_byte_ready <= 1'b0;
                            r_write      <= 1'b1;
                        end
                    end
                end
                S_WRITE: begin
                    r_write    <= 1'b0;
                    r_address  <= r_address + 32'd4;
                    r_count    <= r_count + c_one;
                    r_byte_idx <= 2'd0;
`ifdef LOADER_CHECKSUM_EN
                    r_checksum <= r_checksum + r_data;
`endif
                    if (r_count == c_last_word) begin
                        r_state <= S_DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end else begin
                        r_state      <= S_COLLECT;
                        r_byte_ready <= 1'b1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign byte_ready     = r_byte_ready;
    assign mem_address    = r_address;
    assign mem_data_in    = r_data;
    assign mem_read_write = r_write;
    assign busy           = r_busy;
    assign done           = r_done;
    assign words_written  = r_count;
`ifdef LOADER_CHECKSUM_EN
    assign checksum       = r_checksum;
`endif

endmodule
`default_nettype wire

// File: tb/tb_imem_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_imem_loader
// Purpose  : Self-checking bench for imem_loader (two instances: normal and
//            address-wrapping base) against a cycle-level behavioural model.
// Revision : 1.0
// ============================================================================
module tb_imem_loader;

    localparam logic [31:0] c_base      = 32'h0100_0000;
    localparam logic [31:0] c_wrap_base = 32'hFFFF_FFFC;
    localparam int          c_nw        = 2;
    localparam int          c_cw        = 16;

    logic clock      = 1'b0;
    logic reset      = 1'b0;
    logic start      = 1'b0;
    logic byte_valid = 1'b0;
    logic [7:0] byte_data = 8'd0;

    logic            dut_ready, dut_wr, dut_busy, dut_done;
    logic [31:0]     dut_addr, dut_data;
    logic [c_cw-1:0] dut_ww;
    logic            wrp_ready, wrp_wr, wrp_busy, wrp_done;
    logic [31:0]     wrp_addr, wrp_data;
    logic [c_cw-1:0] wrp_ww;
`ifdef LOADER_CHECKSUM_EN
    logic [31:0]     dut_sum, wrp_sum;
`endif

    imem_loader #(.BASE_ADDR(c_base), .NUM_WORDS(c_nw), .CNT_W(c_cw)) u_dut (
        .clock(clock), .reset(reset), .start(start),
        .byte_valid(byte_valid), .byte_data(byte_data), .byte_ready(dut_ready),
        .mem_address(dut_addr), .mem_data_in(dut_data), .mem_read_write(dut_wr),
        .busy(dut_busy), .done(dut_done), .words_written(dut_ww)
`ifdef LOADER_CHECKSUM_EN
        , .checksum(dut_sum)
`endif
    );

    imem_loader #(.BASE_ADDR(c_wrap_base), .NUM_WORDS(c_nw), .CNT_W(c_cw)) u_wrap (
        .clock(clock), .reset(reset), .start(start),
        .byte_valid(byte_valid), .byte_data(byte_data), .byte_ready(wrp_ready),
        .mem_address(wrp_addr), .mem_data_in(wrp_data), .mem_read_write(wrp_wr),
        .busy(wrp_busy), .done(wrp_done), .words_written(wrp_ww)
`ifdef LOADER_CHECKSUM_EN
        , .checksum(wrp_sum)
`endif
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
    endtask

    // Behavioural model: a session is "waiting for bytes", "writing", or idle/finished.
    bit          m_live = 1'b0;
    logic        m_ready, m_wr, m_busy, m_done, m_fresh;
    logic [31:0] m_off, m_data, m_sum;
    int          m_cnt;
    logic [7:0]  m_q[$];
    int          cyc = 0;

    initial forever begin
        @(posedge clock);
        cyc++;
        if (!reset) begin
            m_live = 1'b1;
            m_ready = 0; m_wr = 0; m_busy = 0; m_done = 0; m_fresh = 1;
            m_off = 0; m_data = 0; m_sum = 0; m_cnt = 0;
            m_q.delete();
        end else if (m_live) begin
            if (m_wr) begin
                m_wr  = 0;
                m_sum = m_sum + m_data;
                m_off = m_off + 32'd4;
                m_cnt++;
                if (m_cnt == c_nw) begin m_busy = 0; m_done = 1; end
                else m_ready = 1;
            end else if (m_ready) begin
                if (byte_valid) begin
                    m_fresh = 0;
                    m_q.push_back(byte_data);
                    if (m_q.size() == 4) begin
                        m_data = {m_q[3], m_q[2], m_q[1], m_q[0]};
                        m_q.delete();
                        m_wr = 1; m_ready = 0;
                    end
                end
            end else if (start) begin
                m_ready = 1; m_busy = 1; m_done = 0;
                m_off = 0; m_cnt = 0; m_sum = 0;
                m_q.delete();
            end
        end
    end

    logic [31:0] log_addr[$], log_data[$], wlog_addr[$];

    initial forever begin
        @(negedge clock);
        if (m_live) begin
            chk("byte_ready", dut_ready, m_ready);
            chk("mem_read_write", dut_wr, m_wr);
            chk("busy", dut_busy, m_busy);
            chk("done", dut_done, m_done);
            chk("mem_address", dut_addr, c_base + m_off);
            chk("words_written", 32'(dut_ww), 32'(m_cnt));
            if (m_wr || m_fresh) chk("mem_data_in", dut_data, m_data);
            chk("wrap byte_ready", wrp_ready, m_ready);
            chk("wrap mem_read_write", wrp_wr, m_wr);
            chk("wrap done", wrp_done, m_done);
            chk("wrap mem_address", wrp_addr, c_wrap_base + m_off);
            if (m_wr) chk("wrap mem_data_in", wrp_data, m_data);
`ifdef LOADER_CHECKSUM_EN
            chk("checksum", dut_sum, m_sum);
            chk("wrap checksum", wrp_sum, m_sum);
`endif
        end
        if (dut_wr) begin log_addr.push_back(dut_addr); log_data.push_back(dut_data); end
        if (wrp_wr) wlog_addr.push_back(wrp_addr);
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic pulse_start(output int t);
        start = 1'b1;
        tick();
        t = cyc;
        start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        int budget = 50;
        byte_valid = 1'b1;
        byte_data  = b;
        while (!dut_ready && budget > 0) begin tick(); budget--; end
        if (budget == 0) chk("byte_ready timeout", dut_ready, 1'b1);
        tick();
        byte_valid = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w, input int gap);
        for (int i = 0; i < 4; i++) begin
            send_byte(w[8*i +: 8]);
            repeat (gap) tick();
        end
    endtask

    task automatic wait_done(output int t);
        int budget = 200;
        while (!dut_done && budget > 0) begin @(negedge clock); budget--; end
        t = cyc;
        chk("done reached", dut_done, 1'b1);
    endtask

    task automatic chk_reset_values(input string tag);
        chk({tag, " byte_ready"}, dut_ready, 1'b0);
        chk({tag, " busy"}, dut_busy, 1'b0);
        chk({tag, " done"}, dut_done, 1'b0);
        chk({tag, " mem_read_write"}, dut_wr, 1'b0);
        chk({tag, " mem_address"}, dut_addr, 32'h0100_0000);
        chk({tag, " mem_data_in"}, dut_data, 32'h0);
        chk({tag, " words_written"}, 32'(dut_ww), 32'h0);
    endtask

    initial begin
        int t0, td;
        logic [31:0] wa, wb;
        int n0;

        reset = 1'b0;
        repeat (3) tick();
        chk_reset_values("reset");
        reset = 1'b1;
        tick();

        // Two back-to-back words; done is set by the 11th edge counting the start edge.
        log_addr.delete(); log_data.delete(); wlog_addr.delete();
        pulse_start(t0);
        send_word(32'h0000_0013, 0);
        send_word(32'h0010_0093, 0);
        wait_done(td);
        chk("t1 done latency", 32'(td - t0), 32'd10);
        chk("t1 write count", 32'(log_addr.size()), 32'd2);
        chk("t1 addr0", log_addr[0], 32'h0100_0000);
        chk("t1 data0", log_data[0], 32'h0000_0013);
        chk("t1 addr1", log_addr[1], 32'h0100_0004);
        chk("t1 data1", log_data[1], 32'h0010_0093);
        chk("wrap write count", 32'(wlog_addr.size()), 32'd2);
        chk("wrap addr0", wlog_addr[0], 32'hFFFF_FFFC);
        chk("wrap addr1", wlog_addr[1], 32'h0000_0000);

        // Restart from DONE, then feed bytes with one idle cycle between each.
        pulse_start(t0);
        chk("restart words_written", 32'(dut_ww), 32'h0);
        chk("restart address", dut_addr, 32'h0100_0000);
        chk("restart done", dut_done, 1'b0);
        n0 = log_addr.size();
        wa = $urandom; wb = $urandom;
        send_word(wa, 1);
        send_word(wb, 1);
        wait_done(td);
        repeat (3) tick();
        chk("gap write count", 32'(log_addr.size() - n0), 32'd2);
        chk("gap data0", log_data[n0], wa);
        chk("gap data1", log_data[n0+1], wb);

        // Wrapping sum of the two words.
        pulse_start(t0);
        send_word(32'hFFFF_FFFF, 0);
        send_word(32'h0000_0002, 0);
        wait_done(td);
`ifdef LOADER_CHECKSUM_EN
        chk("checksum in DONE", dut_sum, 32'h0000_0001);
`endif

        // Abort mid-word with reset, then a fresh session.
        pulse_start(t0);
        send_byte(8'hAA);
        send_byte(8'hBB);
        reset = 1'b0;
        tick();
        chk_reset_values("abort");
        reset = 1'b1;
        tick();
        log_addr.delete(); log_data.delete();
        wa = $urandom; wb = $urandom;
        pulse_start(t0);
        send_byte(wa[7:0]);
        start = 1'b1;             // ignored while collecting
        send_byte(wa[15:8]);
        start = 1'b0;
        send_byte(wa[23:16]);
        send_byte(wa[31:24]);
        send_word(wb, 0);
        wait_done(td);
        chk("abort addr0", log_addr[0], 32'h0100_0000);
        chk("abort data0", log_data[0], wa);
        chk("abort data1", log_data[1], wb);

        // Random traffic: start noise, stalls and occasional resets.
        for (int i = 0; i < 1500; i++) begin
            reset      = ($urandom_range(99) != 0);
            start      = ($urandom_range(9) == 0);
            byte_valid = ($urandom_range(2) != 0);
            byte_data  = 8'($urandom);
            tick();
        end
        reset = 1'b1; start = 1'b0; byte_valid = 1'b0;
        repeat (4) tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
